// File: rtl/cpu_pkg.sv
// Shared definitions for the Sigma CPU microcode sequencing path:
// the sequencer op encoding and the microcode address width.
package cpu_pkg;

  localparam int UC_ADDR_WIDTH = 12;

  // Sequencing ops as driven from the CPU pipeline register.
  // A conditional branch arrives as {0, branch}, i.e. next or jump.
  localparam logic [1:0] SEQ_NEXT   = 2'd0;
  localparam logic [1:0] SEQ_JUMP   = 2'd1;
  localparam logic [1:0] SEQ_CALL   = 2'd2;
  localparam logic [1:0] SEQ_RETURN = 2'd3;

  typedef logic [0:UC_ADDR_WIDTH-1] uc_addr_t;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for the microprogram sequencer. The pointer wraps
// modulo DEPTH with no error flag: a push on a full stack overwrites the
// oldest entry and a pop on an empty stack exposes entry DEPTH-1.
// The top entry is read combinationally so a return can issue its target
// in the same cycle.
module seq_stack #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16,
  parameter int SP_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [0:DATA_WIDTH-1] push_data,
  output logic [0:DATA_WIDTH-1] top_data,
  output logic [SP_W-1:0]       sp
);

  logic [SP_W-1:0]             sp_reg;
  logic [SP_W-1:0]             top_idx;
  logic [DEPTH*DATA_WIDTH-1:0] entries_flat;

  // One register per entry; only the entry under the pointer is written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [0:DATA_WIDTH-1] entry_reg;

    // Clear on reset, capture the pushed return address when selected.
    always_ff @(posedge clock) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (push && (sp_reg == SP_W'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entries_flat[gi*DATA_WIDTH +: DATA_WIDTH] = entry_reg;
  end

  // Stack pointer: post-increment on push, pre-decrement on pop, wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_reg <= '0;
    end else if (push) begin
      sp_reg <= sp_reg + SP_W'(1);
    end else if (pop) begin
      sp_reg <= sp_reg - SP_W'(1);
    end
  end

  assign top_idx = sp_reg - SP_W'(1);

  // Combinational read of the entry just below the pointer.
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == SP_W'(i)) begin
        top_data = entries_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sp = sp_reg;

endmodule

// File: rtl/sequencer.sv
// Microprogram sequencer for the Sigma CPU. Each cycle it selects the
// microcode ROM address from the pipeline-register op (next, jump, call,
// return); the ROM is asynchronous, so address is combinational and the
// ROM word lands in the CPU pipeline register on the following edge.
// pc holds the address after the one last issued, so the CPU reports
// pc-1 as the microinstruction currently in its pipeline.
module sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = UC_ADDR_WIDTH,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic [0:1]            op,
  input  logic [0:ADDR_WIDTH-1] din,
  output logic [0:ADDR_WIDTH-1] address
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [0:ADDR_WIDTH-1] pc;
  logic [0:ADDR_WIDTH-1] addr_next;
  logic [0:ADDR_WIDTH-1] stack_top;
  logic [SP_W-1:0]       sp;
  logic                  push;
  logic                  pop;

  // Address select; forced to zero while reset is held so that ROM word 0
  // is the first fetch after release.
  always_comb begin
    addr_next = pc;
    if (reset) begin
      addr_next = '0;
    end else begin
      case (op)
        SEQ_NEXT:   addr_next = pc;
        SEQ_JUMP:   addr_next = din;
        SEQ_CALL:   addr_next = din;
        SEQ_RETURN: addr_next = stack_top;
        default:    addr_next = pc;
      endcase
    end
  end

  assign address = addr_next;

  // Microprogram counter: one past the address issued this cycle, wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= addr_next + ADDR_WIDTH'(1);
    end
  end

  // A call saves pc, which is already the return point of the call word.
  assign push = !reset && (op == SEQ_CALL);
  assign pop  = !reset && (op == SEQ_RETURN);

  seq_stack #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH      (STACK_DEPTH),
    .SP_W       (SP_W)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top_data  (stack_top),
    .sp        (sp)
  );

endmodule

// File: tb/tb_sequencer.sv
// Bench for the microprogram sequencer: a reference model predicts the
// combinational address for each driven op (queued and compared by a
// monitor) and the pc/sp state after each edge.
module tb_sequencer;

  logic        reset;
  logic        clock;
  logic [0:1]  op;
  logic [0:11] din;
  logic [0:11] address;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_q[$];

  // Reference model state
  logic [11:0] pc_m;
  logic [3:0]  sp_m;
  logic [11:0] stack_m [16];

  sequencer #(.ADDR_WIDTH(12), .STACK_DEPTH(16)) dut (
    .reset   (reset),
    .clock   (clock),
    .op      (op),
    .din     (din),
    .address (address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m = 12'h000;
    sp_m = 4'd0;
    for (int i = 0; i < 16; i++) stack_m[i] = 12'h000;
  endtask

  // Drive one cycle, queue the expected address, then check state after the edge.
  task automatic drive(input logic rst, input logic [1:0] o, input logic [11:0] d);
    logic [11:0] e;
    logic [3:0]  ti;
    @(negedge clock);
    reset = rst;
    op    = o;
    din   = d;
    ti = sp_m - 4'd1;
    if (rst) e = 12'h000;
    else begin
      case (o)
        2'd0:    e = pc_m;
        2'd1:    e = d;
        2'd2:    e = d;
        default: e = stack_m[ti];
      endcase
    end
    exp_q.push_back(e);
    @(posedge clock);
    if (rst) model_reset();
    else begin
      if (o == 2'd2) begin
        stack_m[sp_m] = pc_m;
        sp_m = sp_m + 4'd1;
      end else if (o == 2'd3) begin
        sp_m = sp_m - 4'd1;
      end
      pc_m = e + 12'd1;
    end
    #1;
    check("pc", {20'd0, dut.pc}, {20'd0, pc_m});
    check("sp", {28'd0, dut.sp}, {28'd0, sp_m});
  endtask

  // Monitor: compare the combinational address mid-cycle against the queue.
  always @(negedge clock) begin
    logic [11:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("addr", {20'd0, address}, {20'd0, e});
      $display("op=%0d din=0x%03h reset=%0b address=0x%03h expected=0x%03h",
               op, din, reset, address, e);
    end
  end

  initial begin
    reset = 1'b1;
    op    = 2'd0;
    din   = 12'h000;
    model_reset();

    // Reset with a return op still gives address 0, then sequential fetch.
    drive(1'b1, 2'd3, 12'hABC);
    drive(1'b1, 2'd0, 12'h000);
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd0, 12'h000);
    check("next_pc3", {20'd0, dut.pc}, 32'h003);

    // Jump from pc=5.
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd1, 12'h123);
    check("jump_pc", {20'd0, dut.pc}, 32'h124);
    drive(1'b0, 2'd0, 12'h000);

    // Call from pc=0x010, two nexts, return.
    drive(1'b0, 2'd1, 12'h00F);
    drive(1'b0, 2'd2, 12'h200);
    check("call_pc", {20'd0, dut.pc}, 32'h201);
    check("call_top", {20'd0, dut.stack_top}, 32'h010);
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b0, 2'd3, 12'h000);
    check("ret_pc", {20'd0, dut.pc}, 32'h011);
    check("ret_sp", {28'd0, dut.sp}, 32'd0);

    // Nested calls to depth 3 and LIFO returns.
    drive(1'b0, 2'd2, 12'h100);
    drive(1'b0, 2'd2, 12'h200);
    drive(1'b0, 2'd2, 12'h300);
    drive(1'b0, 2'd3, 12'h000);
    drive(1'b0, 2'd3, 12'h000);
    drive(1'b0, 2'd3, 12'h000);
    check("nest_pc", {20'd0, dut.pc}, 32'h012);

    // Return on an empty stack straight after reset.
    drive(1'b1, 2'd0, 12'h000);
    drive(1'b0, 2'd3, 12'h000);
    check("uflow_sp", {28'd0, dut.sp}, 32'd15);

    // 17 calls on a 16-deep stack, then unwind all of them.
    drive(1'b1, 2'd0, 12'h000);
    for (int i = 0; i < 17; i++) drive(1'b0, 2'd2, 12'(16 * i + 3));
    check("oflow_sp", {28'd0, dut.sp}, 32'd1);
    for (int i = 0; i < 17; i++) drive(1'b0, 2'd3, 12'h000);

    // pc wrap at the top of the address space.
    drive(1'b0, 2'd1, 12'hFFE);
    drive(1'b0, 2'd0, 12'h000);
    check("wrap_pc", {20'd0, dut.pc}, 32'h000);

    // Mid-program reset after a call discards everything.
    drive(1'b0, 2'd1, 12'h050);
    drive(1'b0, 2'd2, 12'h200);
    check("mid_pc", {20'd0, dut.pc}, 32'h201);
    drive(1'b1, 2'd2, 12'h400);
    check("mid_clr", {31'd0, |dut.u_stack.entries_flat}, 32'd0);
    drive(1'b0, 2'd0, 12'h000);

    // Random ops with occasional reset.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
    end

    @(negedge clock);
    #4;
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
